ks_data_path_p: RTL and testbench
=================================

# ks_data_path_p

Parametrised successor of the K&S processor data path: program counter, instruction register, NREGS-entry register file, four-operation ALU with registered flags, and instruction decoder. It sits between the K&S control unit and a single-port program/data RAM. New capabilities:
- generic data width, address width and register count
- a fully defined SUB
- a RAM ready handshake that stalls memory-sourced updates
- a retired-fetch counter

## Interface
Parameters:
- DATA_W, 16, data/instruction width; ≥16; opcode is always bits [DATA_W-1:DATA_W-8]
- ADDR_W, 5, RAM address / PC width
- NREGS, 4, register count, power of 2; RA_W = $clog2(NREGS); requires ADDR_W+RA_W ≤ DATA_W-8 and 2·RA_W ≤ DATA_W-8

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high, priority over all enables
- branch  in  1  PC load source: 1 = decoded mem_addr, 0 = PC+1
- pc_enable  in  1  PC update enable
- ir_enable  in  1  IR load from data_in
- addr_sel  in  1  ram_addr source: 1 = decoded mem_addr, 0 = PC
- c_sel  in  1  register write source: 1 = data_in, 0 = ALU result
- operation  in  2  00 ADD, 01 AND, 10 OR, 11 SUB
- write_reg_enable  in  1  write bus C into register c_addr
- flags_reg_enable  in  1  capture ALU flags
- mem_ready  in  1  RAM has valid data_in / accepted access this cycle
- decoded_instruction  out  decoded_instruction_type  from k_and_s_pkg
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags
- ram_addr  out  ADDR_W  RAM address
- data_out  out  DATA_W  store data (bus A)
- data_in  in  DATA_W  RAM read data
- stall  out  1  combinational; memory-sourced update pending without mem_ready
- fetch_count  out  32  count of completed IR loads

## Operation
- Decoder (combinational on IR opcode; unlisted fields 0):
  - LOAD 0x81 / STORE 0x82: c_addr and a_addr = IR[ADDR_W+RA_W-1:ADDR_W]; mem_addr = IR[ADDR_W-1:0]
  - MOVE 0x91: c_addr = IR[2RA_W-1:RA_W]; a_addr = b_addr = IR[RA_W-1:0]. Control uses OR, so result = A.
  - ADD A1, SUB A2, AND A3, OR A4: a_addr = IR[RA_W-1:0]; b_addr = c_addr = IR[2RA_W-1:RA_W]
  - BRANCH 01, BZERO 02, BNEG 03, BOV 05, BNOV 06, BNNEG 0A: mem_addr = IR[ADDR_W-1:0]
  - NOP 00, HALT FF: no fields
  - Any other opcode decodes as I_NOP.
- Register file: two async reads (bus A, bus B), one sync write. Bus C = c_sel ? data_in : alu_out.
- ALU, all DATA_W-bit modular:
  - ADD: uov = carry out of MSB; sov = carry into MSB XOR carry out
  - SUB = A − B: uov = borrow (A < B unsigned); sov = operand signs differ AND result sign ≠ sign of A
  - AND / OR: uov = sov = 0
  - zero = ~|result; neg = result[MSB]
- Flags register loads all four flags when flags_reg_enable is high and no stall.
- PC: when pc_enable and no stall: branch ? mem_addr : PC+1, wrapping 2^ADDR_W−1 → 0.
- data_out = bus A at all times.
- Handshake:
  - mem_op = ir_enable | (write_reg_enable & c_sel)
  - stall = mem_op & ~mem_ready
  - While stall: IR, register file, PC, flags and fetch_count all hold. The control unit holds its state and keeps its controls steady until stall drops.
  - ALU-sourced writes (c_sel=0) ignore mem_ready.
- fetch_count increments on each IR load (ir_enable & mem_ready), wraps at 2^32.

## Timing
- Reset (rst high at an edge): PC=0, IR=0 (decodes I_NOP), all registers=0, flags=0, fetch_count=0. Reset mid-stall clears everything; stall then follows the inputs only.
- Latency:
  - IR load, register write, PC update, flags: one edge after the enabling cycle
  - decoded_instruction is valid combinationally in the cycle after the IR load
- ram_addr, data_out, stall: combinational, same cycle.
- Simultaneous events:
  - Register write and read of the same register in one cycle: the read returns the old value.
  - ir_enable with write_reg_enable: both capture the same data_in.
  - pc_enable with stall: the PC holds.

## Test plan
- Reset, then fetch with mem_ready=1 and data_in=0xA106 -> after 1 edge decoded=I_ADD, a_addr=2, b_addr=c_addr=1; fetch_count=1; PC=1 with pc_enable.
- R1=0x7FFF, R2=0x0001, ADD into R1 with flags enabled -> R1=0x8000, neg=1, sov=1, uov=0, zero=0.
- R1=0x0000, R2=0x0001, SUB (A=R2, B=R1 per fields; also swap) -> R1−R2 gives 0xFFFF with uov=1; 0x0001−0x0001 gives zero=1, uov=0.
- LOAD with mem_ready low 3 cycles then high, data_in=0x1234 -> stall=1 for 3 cycles, register unchanged; 0x1234 written on the ready edge.
- PC=31 (ADDR_W=5), pc_enable with branch=0 -> PC=0; branch=1 with IR=0x0113 -> PC=0x13.
- Parameter sweep DATA_W=32, ADDR_W=8, NREGS=8: STORE field decode, ram_addr mux and ADD carry at bit 31 correct; rst asserted mid-stall clears PC, IR and fetch_count.

Source files
------------

// File: rtl/ks_data_path_p.sv
// K&S processor data path, parametrised: PC, IR, register file, four-op ALU with
// registered flags, instruction decoder, RAM ready handshake and retired-fetch counter.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNOV,
    I_BNNEG,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_SUB = 2'b11
  } alu_op_t;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BZERO  = 8'h02;
  localparam logic [7:0] OPC_BNEG   = 8'h03;
  localparam logic [7:0] OPC_BOV    = 8'h05;
  localparam logic [7:0] OPC_BNOV   = 8'h06;
  localparam logic [7:0] OPC_BNNEG  = 8'h0A;
  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

endpackage

module ks_data_path_p
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic                    mem_ready,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    stall,
  output logic [31:0]             fetch_count
);

  localparam int RA_W = $clog2(NREGS);
  localparam int MSB  = DATA_W - 1;

  // Architectural state
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] regs [NREGS];

  // Decoded fields
  logic [7:0]        opcode;
  logic [RA_W-1:0]   a_addr;
  logic [RA_W-1:0]   b_addr;
  logic [RA_W-1:0]   c_addr;
  logic [ADDR_W-1:0] mem_addr;

  // Data path
  logic [DATA_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_b;
  logic [DATA_W-1:0] bus_c;
  logic [DATA_W-1:0] alu_out;
  logic              alu_uov;
  logic              alu_sov;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;

  // Handshake-qualified enables
  logic mem_op;
  logic ir_load;
  logic reg_wr;
  logic flags_wr;
  logic pc_wr;

  assign opcode = ir[MSB -: 8];

  // Only the opcode and the low operand fields are decoded; the rest is don't-care.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir;

  // NOTE: every output of a combinational block gets a default first, so no
  // opcode path can leave a signal unassigned and infer a latch.
  always_comb begin
    decoded_instruction = I_NOP;
    a_addr              = '0;
    b_addr              = '0;
    c_addr              = '0;
    mem_addr            = '0;
    case (opcode)
      OPC_LOAD, OPC_STORE: begin
        decoded_instruction = (opcode == OPC_LOAD) ? I_LOAD : I_STORE;
        c_addr              = ir[ADDR_W +: RA_W];
        a_addr              = ir[ADDR_W +: RA_W];
        mem_addr            = ir[ADDR_W-1:0];
      end
      OPC_MOVE: begin
        decoded_instruction = I_MOVE;
        c_addr              = ir[RA_W +: RA_W];
        a_addr              = ir[RA_W-1:0];
        b_addr              = ir[RA_W-1:0];
      end
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
        case (opcode)
          OPC_ADD: decoded_instruction = I_ADD;
          OPC_SUB: decoded_instruction = I_SUB;
          OPC_AND: decoded_instruction = I_AND;
          default: decoded_instruction = I_OR;
        endcase
        a_addr = ir[RA_W-1:0];
        b_addr = ir[RA_W +: RA_W];
        c_addr = ir[RA_W +: RA_W];
      end
      OPC_BRANCH: begin decoded_instruction = I_BRANCH; mem_addr = ir[ADDR_W-1:0]; end
      OPC_BZERO:  begin decoded_instruction = I_BZERO;  mem_addr = ir[ADDR_W-1:0]; end
      OPC_BNEG:   begin decoded_instruction = I_BNEG;   mem_addr = ir[ADDR_W-1:0]; end
      OPC_BOV:    begin decoded_instruction = I_BOV;    mem_addr = ir[ADDR_W-1:0]; end
      OPC_BNOV:   begin decoded_instruction = I_BNOV;   mem_addr = ir[ADDR_W-1:0]; end
      OPC_BNNEG:  begin decoded_instruction = I_BNNEG;  mem_addr = ir[ADDR_W-1:0]; end
      OPC_HALT:   decoded_instruction = I_HALT;
      default:    decoded_instruction = I_NOP;
    endcase
  end

  // Read ports are asynchronous, so a same-cycle write is seen only after the edge.
  assign bus_a    = regs[a_addr];
  assign bus_b    = regs[b_addr];
  assign data_out = bus_a;

  assign sum_ext  = {1'b0, bus_a} + {1'b0, bus_b};
  assign diff_ext = {1'b0, bus_a} - {1'b0, bus_b};

  always_comb begin
    alu_out = '0;
    alu_uov = 1'b0;
    alu_sov = 1'b0;
    case (alu_op_t'(operation))
      OP_ADD: begin
        alu_out = sum_ext[MSB:0];
        alu_uov = sum_ext[DATA_W];
        // carry into the MSB is recovered from the sum bit and both operand bits
        alu_sov = (sum_ext[MSB] ^ bus_a[MSB] ^ bus_b[MSB]) ^ sum_ext[DATA_W];
      end
      OP_SUB: begin
        alu_out = diff_ext[MSB:0];
        alu_uov = diff_ext[DATA_W];
        alu_sov = (bus_a[MSB] ^ bus_b[MSB]) & (diff_ext[MSB] ^ bus_a[MSB]);
      end
      OP_AND:  alu_out = bus_a & bus_b;
      default: alu_out = bus_a | bus_b;
    endcase
  end

  assign bus_c = c_sel ? data_in : alu_out;

  // A memory-sourced update without mem_ready freezes every state element.
  assign mem_op   = ir_enable | (write_reg_enable & c_sel);
  assign stall    = mem_op & ~mem_ready;
  assign ir_load  = ir_enable & ~stall;
  assign reg_wr   = write_reg_enable & ~stall;
  assign flags_wr = flags_reg_enable & ~stall;
  assign pc_wr    = pc_enable & ~stall;

  assign ram_addr = addr_sel ? mem_addr : pc;

  // NOTE: the register file is a small flop array rather than a RAM macro, and
  // it must read zero after reset, so it is cleared along with the other state.
  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values of the buses regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= '0;
      ir                <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
      fetch_count       <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (ir_load) begin
        ir          <= data_in;
        fetch_count <= fetch_count + 32'd1;
      end
      if (reg_wr) regs[c_addr] <= bus_c;
      if (flags_wr) begin
        zero_op           <= ~|alu_out;
        neg_op            <= alu_out[MSB];
        unsigned_overflow <= alu_uov;
        signed_overflow   <= alu_sov;
      end
      if (pc_wr) pc <= branch ? mem_addr : pc + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_ks_data_path_p.sv
// Bench for ks_data_path_p: ALU vector table, handshake/PC corner sequences,
// randomized traffic against an arithmetic model, and a wide-parameter instance.
module tb_ks_data_path_p;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- default instance: DATA_W=16, ADDR_W=5, NREGS=4 ----------------
  logic rst, branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic write_reg_enable, flags_reg_enable, mem_ready;
  logic [1:0] operation;
  logic [15:0] data_in, data_out;
  logic [4:0] ram_addr;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow, stall;
  logic [31:0] fetch_count;
  decoded_instruction_type decoded;

  ks_data_path_p dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .mem_ready(mem_ready), .decoded_instruction(decoded), .zero_op(zero_op),
    .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .ram_addr(ram_addr), .data_out(data_out),
    .data_in(data_in), .stall(stall), .fetch_count(fetch_count)
  );

  // ---------------- wide instance: DATA_W=32, ADDR_W=8, NREGS=8 ----------------
  logic w_rst, w_branch, w_pc_enable, w_ir_enable, w_addr_sel, w_c_sel;
  logic w_write_reg_enable, w_flags_reg_enable, w_mem_ready;
  logic [1:0] w_operation;
  logic [31:0] w_data_in, w_data_out;
  logic [7:0] w_ram_addr;
  logic w_zero_op, w_neg_op, w_unsigned_overflow, w_signed_overflow, w_stall;
  logic [31:0] w_fetch_count;
  decoded_instruction_type w_decoded;

  ks_data_path_p #(.DATA_W(32), .ADDR_W(8), .NREGS(8)) dut_w (
    .clk(clk), .rst(w_rst), .branch(w_branch), .pc_enable(w_pc_enable),
    .ir_enable(w_ir_enable), .addr_sel(w_addr_sel), .c_sel(w_c_sel),
    .operation(w_operation), .write_reg_enable(w_write_reg_enable),
    .flags_reg_enable(w_flags_reg_enable), .mem_ready(w_mem_ready),
    .decoded_instruction(w_decoded), .zero_op(w_zero_op), .neg_op(w_neg_op),
    .unsigned_overflow(w_unsigned_overflow), .signed_overflow(w_signed_overflow),
    .ram_addr(w_ram_addr), .data_out(w_data_out), .data_in(w_data_in),
    .stall(w_stall), .fetch_count(w_fetch_count)
  );

  // ---------------- behavioural model of the 16-bit instance ----------------
  logic [15:0] m_regs [4];
  logic [15:0] m_ir;
  int          m_pc;
  int          m_fc;
  logic        m_z, m_n, m_u, m_s;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
    m_ir = 16'h0; m_pc = 0; m_fc = 0;
    m_z = 0; m_n = 0; m_u = 0; m_s = 0;
  endtask

  function automatic void m_decode(input logic [15:0] ir, output decoded_instruction_type d,
                                   output int a, output int b, output int c, output int m);
    int op, mem, ls, lo, hi;
    op = int'(ir) / 256; mem = int'(ir) % 32; ls = (int'(ir) / 32) % 4;
    lo = int'(ir) % 4;   hi = (int'(ir) / 4) % 4;
    d = I_NOP; a = 0; b = 0; c = 0; m = 0;
    case (op)
      'h81: begin d = I_LOAD;  a = ls; c = ls; m = mem; end
      'h82: begin d = I_STORE; a = ls; c = ls; m = mem; end
      'h91: begin d = I_MOVE;  c = hi; a = lo; b = lo; end
      'hA1: begin d = I_ADD;   a = lo; b = hi; c = hi; end
      'hA2: begin d = I_SUB;   a = lo; b = hi; c = hi; end
      'hA3: begin d = I_AND;   a = lo; b = hi; c = hi; end
      'hA4: begin d = I_OR;    a = lo; b = hi; c = hi; end
      'h01: begin d = I_BRANCH; m = mem; end
      'h02: begin d = I_BZERO;  m = mem; end
      'h03: begin d = I_BNEG;   m = mem; end
      'h05: begin d = I_BOV;    m = mem; end
      'h06: begin d = I_BNOV;   m = mem; end
      'h0A: begin d = I_BNNEG;  m = mem; end
      'hFF: d = I_HALT;
      default: d = I_NOP;
    endcase
  endfunction

  // Flags from signed/unsigned integer ranges rather than carry bits.
  function automatic void m_alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                                output logic [15:0] res, output logic z, output logic n,
                                output logic u, output logic s);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    u = 1'b0; s = 1'b0; r = 0;
    case (op)
      2'b00: begin r = ua + ub; u = (r > 65535); sr = sa + sb; s = (sr > 32767) || (sr < -32768); end
      2'b11: begin r = ua - ub; u = (ua < ub);   sr = sa - sb; s = (sr > 32767) || (sr < -32768); end
      2'b01: r = ua & ub;
      default: r = ua | ub;
    endcase
    res = 16'((r + 65536) % 65536);
    z = (res == 16'h0);
    n = (res >= 16'h8000);
  endfunction

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    decoded_instruction_type d;
    int a, b, c, m;
    logic [15:0] res;
    logic z, n, u, s, st;
    #1;
    m_decode(m_ir, d, a, b, c, m);
    st = (ir_enable || (write_reg_enable && c_sel)) && !mem_ready;
    check("stall", stall, st);
    check("decoded", decoded, d);
    check("ram_addr", ram_addr, addr_sel ? m : m_pc);
    check("data_out", data_out, m_regs[a]);
    m_alu(m_regs[a], m_regs[b], operation, res, z, n, u, s);
    if (rst) m_reset();
    else if (!st) begin
      if (flags_reg_enable) begin m_z = z; m_n = n; m_u = u; m_s = s; end
      if (write_reg_enable) m_regs[c] = c_sel ? data_in : res;
      if (ir_enable) begin m_ir = data_in; m_fc++; end
      if (pc_enable) m_pc = branch ? m : (m_pc + 1) % 32;
    end
    @(posedge clk);
    #1;
    check("zero_op", zero_op, m_z);
    check("neg_op", neg_op, m_n);
    check("uov", unsigned_overflow, m_u);
    check("sov", signed_overflow, m_s);
    check("fetch_count", fetch_count, m_fc);
  endtask

  task automatic idle();
    rst = 0; branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    operation = 2'b00; write_reg_enable = 0; flags_reg_enable = 0;
    mem_ready = 1; data_in = 16'h0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); idle();
  endtask

  task automatic fetch(input logic [15:0] word, input logic pc_en);
    idle(); ir_enable = 1; data_in = word; pc_enable = pc_en; tick(); idle();
  endtask

  task automatic write_reg(input int r, input logic [15:0] val);
    fetch(16'h8100 | 16'(r << 5), 1'b0);
    write_reg_enable = 1; c_sel = 1; data_in = val; tick(); idle();
  endtask

  task automatic read_reg(input int r, output logic [15:0] v);
    fetch(16'h8200 | 16'(r << 5), 1'b0);
    #1 v = data_out;
  endtask

  typedef struct {
    logic [7:0]  opc;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z, n, u, s;
    decoded_instruction_type dec;
  } alu_vec_t;

  alu_vec_t vecs [11];
  logic [7:0] opc_list [15] = '{8'h00, 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                                8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'hFF};

  initial begin
    logic [15:0] v;

    vecs[0]  = '{8'hA1, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, I_ADD};
    vecs[1]  = '{8'hA2, 2'b11, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, I_SUB};
    vecs[2]  = '{8'hA2, 2'b11, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, I_SUB};
    vecs[3]  = '{8'hA2, 2'b11, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, I_SUB};
    vecs[4]  = '{8'hA1, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, I_ADD};
    vecs[5]  = '{8'hA1, 2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, I_ADD};
    vecs[6]  = '{8'hA2, 2'b11, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, I_SUB};
    vecs[7]  = '{8'hA2, 2'b11, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1, I_SUB};
    vecs[8]  = '{8'hA3, 2'b01, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, I_AND};
    vecs[9]  = '{8'hA4, 2'b10, 16'h8001, 16'h0100, 16'h8101, 1'b0, 1'b1, 1'b0, 1'b0, I_OR};
    vecs[10] = '{8'h91, 2'b10, 16'h5A5A, 16'h1234, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, I_MOVE};

    idle(); rst = 1;
    w_rst = 1; w_branch = 0; w_pc_enable = 0; w_ir_enable = 0; w_addr_sel = 0; w_c_sel = 0;
    w_operation = 2'b00; w_write_reg_enable = 0; w_flags_reg_enable = 0;
    w_mem_ready = 1; w_data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1 idle(); m_reset();

    // Reset state and first fetch
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_pc", ram_addr, 5'd0);
    check("rst_dec", decoded, I_NOP);
    check("rst_fc", fetch_count, 32'd0);
    check("rst_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 4'b0000);
    check("rst_data_out", data_out, 16'h0);
    fetch(16'hA106, 1'b1);
    #1;
    check("fetch_dec", decoded, I_ADD);
    check("fetch_fc", fetch_count, 32'd1);
    check("fetch_pc", ram_addr, 5'd1);

    // ALU vector table: A in R2 (IR[1:0]=2), B and C in R1 (IR[3:2]=1)
    for (int i = 0; i < 11; i++) begin
      write_reg(2, vecs[i].a);
      write_reg(1, vecs[i].b);
      fetch({vecs[i].opc, 8'h06}, 1'b0);
      #1 check($sformatf("vec%0d_dec", i), decoded, vecs[i].dec);
      check($sformatf("vec%0d_busa", i), data_out, vecs[i].a);
      operation = vecs[i].op; write_reg_enable = 1; flags_reg_enable = 1;
      tick(); idle();
      check($sformatf("vec%0d_flags", i),
            {zero_op, neg_op, unsigned_overflow, signed_overflow},
            {vecs[i].z, vecs[i].n, vecs[i].u, vecs[i].s});
      read_reg(1, v);
      check($sformatf("vec%0d_res", i), v, vecs[i].res);
    end

    // LOAD held off by mem_ready for three cycles
    do_reset();
    write_reg(3, 16'hBEEF);
    fetch(16'h816A, 1'b0);
    write_reg_enable = 1; c_sel = 1; data_in = 16'h1234; mem_ready = 0;
    pc_enable = 1; flags_reg_enable = 1; addr_sel = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("ld_stall", stall, 1'b1);
      check("ld_addr", ram_addr, 5'h0A);
      check("ld_hold", data_out, 16'hBEEF);
      tick();
    end
    mem_ready = 1; tick(); idle();
    #1 check("ld_pc_once", ram_addr, 5'd1);
    read_reg(3, v);
    check("ld_value", v, 16'h1234);

    // PC wrap and branch
    do_reset();
    pc_enable = 1;
    for (int i = 0; i < 31; i++) tick();
    #1 check("pc_31", ram_addr, 5'd31);
    tick();
    check("pc_wrap", ram_addr, 5'd0);
    fetch(16'h0113, 1'b0);
    #1 check("br_dec", decoded, I_BRANCH);
    pc_enable = 1; branch = 1; tick(); idle();
    check("br_pc", ram_addr, 5'h13);
    addr_sel = 1;
    #1 check("br_mem_addr", ram_addr, 5'h13);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      ir_enable = ($urandom_range(0, 2) == 0);
      write_reg_enable = 1'($urandom);
      c_sel = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      pc_enable = 1'($urandom);
      branch = 1'($urandom);
      addr_sel = 1'($urandom);
      flags_reg_enable = 1'($urandom);
      operation = 2'($urandom);
      data_in = {($urandom_range(0, 7) == 0) ? 8'($urandom) : opc_list[$urandom_range(0, 14)],
                 8'($urandom)};
      tick();
    end
    idle();

    // Wide instance: STORE decode, 32-bit carry, reset mid-stall
    @(posedge clk); #1 w_rst = 0;
    w_ir_enable = 1; w_data_in = 32'h8100_0540; @(posedge clk); #1;
    w_ir_enable = 0; w_write_reg_enable = 1; w_c_sel = 1; w_data_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    w_write_reg_enable = 0; w_ir_enable = 1; w_data_in = 32'h8100_0641; @(posedge clk); #1;
    w_ir_enable = 0; w_write_reg_enable = 1; w_data_in = 32'h0000_0001; @(posedge clk); #1;
    w_write_reg_enable = 0; w_c_sel = 0;
    w_ir_enable = 1; w_data_in = 32'h8200_05C7; @(posedge clk); #1;
    w_ir_enable = 0; w_addr_sel = 1;
    #1;
    check("w_store_dec", w_decoded, I_STORE);
    check("w_store_addr", w_ram_addr, 8'hC7);
    check("w_store_data", w_data_out, 32'hFFFF_FFFF);
    w_addr_sel = 0;
    w_ir_enable = 1; w_data_in = 32'hA100_0035; @(posedge clk); #1;
    w_ir_enable = 0;
    check("w_add_dec", w_decoded, I_ADD);
    w_operation = 2'b00; w_write_reg_enable = 1; w_flags_reg_enable = 1; @(posedge clk); #1;
    w_write_reg_enable = 0; w_flags_reg_enable = 0;
    check("w_add_flags", {w_zero_op, w_neg_op, w_unsigned_overflow, w_signed_overflow}, 4'b1010);
    w_ir_enable = 1; w_data_in = 32'h8200_0600; @(posedge clk); #1;
    w_ir_enable = 0;
    check("w_add_res", w_data_out, 32'h0);
    check("w_fc", w_fetch_count, 32'd5);
    w_pc_enable = 1;
    repeat (3) @(posedge clk);
    #1 check("w_pc3", w_ram_addr, 8'd3);
    w_ir_enable = 1; w_mem_ready = 0; w_data_in = 32'hFF00_0000;
    #1 check("w_stall", w_stall, 1'b1);
    @(posedge clk); #1;
    check("w_stall_pc", w_ram_addr, 8'd3);
    check("w_stall_fc", w_fetch_count, 32'd5);
    w_rst = 1;
    #1 check("w_rst_stall", w_stall, 1'b1);
    @(posedge clk); #1;
    w_rst = 0; w_ir_enable = 0; w_pc_enable = 0; w_mem_ready = 1;
    #1;
    check("w_rst_pc", w_ram_addr, 8'd0);
    check("w_rst_fc", w_fetch_count, 32'd0);
    check("w_rst_dec", w_decoded, I_NOP);
    check("w_rst_nostall", w_stall, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
